copperv_lsu: RTL

Parametrised load/store unit between the copperv control/datapath and the split data-read (`dr_*`) and data-write (`dw_*`) buses.
- Accepts one memory request per handshake from the core.
- Drives full valid/ready bus handshakes with held address/data.
- Tracks up to `DEPTH` outstanding transactions in a program-order queue.
- Returns aligned, sign/zero-extended load data and store status to the core strictly in order.

---
 rtl/copperv_lsu_if.sv | 49 ++++
 rtl/copperv_lsu.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/copperv_lsu_if.sv
// Core request/response and split dr/dw data-bus signals of the copperv load/store unit.
// The slave modport is the LSU's view; the master modport is the core/memory environment's view.
interface copperv_lsu_if #(
    parameter int BUS_WIDTH = 32
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_store;
    logic [2:0]             req_funct;
    logic [31:0]            req_addr;
    logic [31:0]            req_wdata;
    logic                   resp_valid;
    logic [31:0]            resp_data;
    logic                   resp_err;

    logic                   dr_addr_valid;
    logic                   dr_addr_ready;
    logic [31:0]            dr_addr;
    logic                   dr_data_valid;
    logic                   dr_data_ready;
    logic [BUS_WIDTH-1:0]   dr_data;

    logic                   dw_data_addr_valid;
    logic                   dw_data_addr_ready;
    logic [31:0]            dw_addr;
    logic [BUS_WIDTH-1:0]   dw_data;
    logic [BUS_WIDTH/8-1:0] dw_strobe;
    logic                   dw_resp_valid;
    logic                   dw_resp_ready;
    logic                   dw_resp;

    modport slave (
        input  req_valid, req_store, req_funct, req_addr, req_wdata,
        output req_ready, resp_valid, resp_data, resp_err,
        output dr_addr_valid, dr_addr, dr_data_ready,
        input  dr_addr_ready, dr_data_valid, dr_data,
        output dw_data_addr_valid, dw_addr, dw_data, dw_strobe, dw_resp_ready,
        input  dw_data_addr_ready, dw_resp_valid, dw_resp
    );

    modport master (
        output req_valid, req_store, req_funct, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_data, resp_err,
        input  dr_addr_valid, dr_addr, dr_data_ready,
        output dr_addr_ready, dr_data_valid, dr_data,
        input  dw_data_addr_valid, dw_addr, dw_data, dw_strobe, dw_resp_ready,
        output dw_data_addr_ready, dw_resp_valid, dw_resp
    );
endinterface

// File: rtl/copperv_lsu.sv
// copperv load/store unit: in-order queue of outstanding loads/stores over the split dr/dw buses.
// Define COPPERV_LSU_MISALIGN_TRAP_EN to turn misaligned half/word accesses into error responses.
module copperv_lsu #(
    parameter int BUS_WIDTH = 32,
    parameter int DEPTH     = 2
) (
    input logic          clk,
    input logic          rst,
    copperv_lsu_if.slave bus
);
    localparam int STRB_W    = BUS_WIDTH / 8;
    localparam int LANE_BITS = $clog2(STRB_W);
    localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W     = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        KIND_LOAD  = 2'd0,
        KIND_STORE = 2'd1,
        KIND_ERR   = 2'd2
    } kind_e;

    typedef struct packed {
        kind_e                kind;
        logic [2:0]           funct;
        logic [LANE_BITS-1:0] lane;
    } entry_t;

    entry_t               q_mem_q [DEPTH];
    entry_t               q_mem_d [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic                 dr_addr_valid_q, dr_addr_valid_d;
    logic [31:0]          dr_addr_q, dr_addr_d;
    logic                 dw_valid_q, dw_valid_d;
    logic [31:0]          dw_addr_q, dw_addr_d;
    logic [BUS_WIDTH-1:0] dw_data_q, dw_data_d;
    logic [STRB_W-1:0]    dw_strobe_q, dw_strobe_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [31:0]          resp_data_q, resp_data_d;
    logic                 resp_err_q, resp_err_d;

    logic                 full, empty, req_ready, accept, pop;
    logic [31:0]          eff_addr, bus_addr;
    logic [LANE_BITS-1:0] lane;
    logic [STRB_W-1:0]    strb_base;
    kind_e                new_kind;
    entry_t               head;
    logic [31:0]          ld_word;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = q_mem_q[rd_ptr_q];

    // Gated by rst so nothing is accepted while reset is held.
    assign req_ready = rst && !full
                     && !(dr_addr_valid_q && !bus.dr_addr_ready)
                     && !(dw_valid_q && !bus.dw_data_addr_ready);
    assign accept = bus.req_valid && req_ready;

    always_comb begin
        eff_addr = bus.req_addr;
        if (bus.req_funct[1:0] == 2'b01) begin
            eff_addr[0] = 1'b0;
        end else if (bus.req_funct[1]) begin
            eff_addr[1:0] = 2'b00;
        end
        lane     = eff_addr[LANE_BITS-1:0];
        bus_addr = {eff_addr[31:LANE_BITS], {LANE_BITS{1'b0}}};
        case (bus.req_funct[1:0])
            2'b00:   strb_base = STRB_W'(4'b0001);
            2'b01:   strb_base = STRB_W'(4'b0011);
            default: strb_base = STRB_W'(4'b1111);
        endcase
        new_kind = bus.req_store ? KIND_STORE : KIND_LOAD;
`ifdef COPPERV_LSU_MISALIGN_TRAP_EN
        if ((bus.req_funct[1:0] == 2'b01 && bus.req_addr[0]) ||
            (bus.req_funct[1] && bus.req_addr[1:0] != 2'b00)) begin
            new_kind = KIND_ERR;
        end
`endif
    end

    // Bus request channels: hold until handshake, reload on a new accept.
    always_comb begin
        dr_addr_valid_d = dr_addr_valid_q;
        dr_addr_d       = dr_addr_q;
        dw_valid_d      = dw_valid_q;
        dw_addr_d       = dw_addr_q;
        dw_data_d       = dw_data_q;
        dw_strobe_d     = dw_strobe_q;
        if (dr_addr_valid_q && bus.dr_addr_ready) dr_addr_valid_d = 1'b0;
        if (dw_valid_q && bus.dw_data_addr_ready) dw_valid_d = 1'b0;
        if (accept && new_kind == KIND_LOAD) begin
            dr_addr_valid_d = 1'b1;
            dr_addr_d       = bus_addr;
        end
        if (accept && new_kind == KIND_STORE) begin
            dw_valid_d  = 1'b1;
            dw_addr_d   = bus_addr;
            dw_data_d   = {(BUS_WIDTH/32){bus.req_wdata}} << {lane, 3'b000};
            dw_strobe_d = strb_base << lane;
        end
    end

    assign bus.dr_data_ready = !empty && head.kind == KIND_LOAD;
    assign bus.dw_resp_ready = !empty && head.kind == KIND_STORE;

    always_comb begin
        ld_word      = 32'(bus.dr_data >> {head.lane, 3'b000});
        pop          = 1'b0;
        resp_data_d  = '0;
        resp_err_d   = 1'b0;
        if (!empty) begin
            case (head.kind)
                KIND_LOAD: if (bus.dr_data_valid) begin
                    pop = 1'b1;
                    case (head.funct[1:0])
                        2'b00:   resp_data_d = {{24{ld_word[7] & ~head.funct[2]}}, ld_word[7:0]};
                        2'b01:   resp_data_d = {{16{ld_word[15] & ~head.funct[2]}}, ld_word[15:0]};
                        default: resp_data_d = ld_word;
                    endcase
                end
                KIND_STORE: if (bus.dw_resp_valid) begin
                    pop        = 1'b1;
                    resp_err_d = !bus.dw_resp;
                end
                default: begin
                    pop        = 1'b1;
                    resp_err_d = 1'b1;
                end
            endcase
        end
        resp_valid_d = pop;
    end

    always_comb begin
        q_mem_d  = q_mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept) begin
            q_mem_d[wr_ptr_q] = '{kind: new_kind, funct: bus.req_funct, lane: lane};
            wr_ptr_d          = ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        if (accept && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !accept) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_mem_q         <= '{default: '0};
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            dr_addr_valid_q <= 1'b0;
            dr_addr_q       <= '0;
            dw_valid_q      <= 1'b0;
            dw_addr_q       <= '0;
            dw_data_q       <= '0;
            dw_strobe_q     <= '0;
            resp_valid_q    <= 1'b0;
            resp_data_q     <= '0;
            resp_err_q      <= 1'b0;
        end else begin
            q_mem_q         <= q_mem_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            dr_addr_valid_q <= dr_addr_valid_d;
            dr_addr_q       <= dr_addr_d;
            dw_valid_q      <= dw_valid_d;
            dw_addr_q       <= dw_addr_d;
            dw_data_q       <= dw_data_d;
            dw_strobe_q     <= dw_strobe_d;
            resp_valid_q    <= resp_valid_d;
            resp_data_q     <= resp_data_d;
            resp_err_q      <= resp_err_d;
        end
    end

    assign bus.req_ready          = req_ready;
    assign bus.dr_addr_valid      = dr_addr_valid_q;
    assign bus.dr_addr            = dr_addr_q;
    assign bus.dw_data_addr_valid = dw_valid_q;
    assign bus.dw_addr            = dw_addr_q;
    assign bus.dw_data            = dw_data_q;
    assign bus.dw_strobe          = dw_strobe_q;
    assign bus.resp_valid         = resp_valid_q;
    assign bus.resp_data          = resp_data_q;
    assign bus.resp_err           = resp_err_q;
endmodule
